tf_seq_ctrl: RTL and testbench

TF_SEQ_CTRL -- requirements
Module: tf_seq_ctrl

---
 rtl/tf_seq_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_tf_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tf_seq_ctrl.sv
// tf_seq_ctrl: walks the twiddle-factor ROM one stage at a time. For each stage it
// fetches WPS words into the base/const buses, pulses TF_wen once, then streams
// TF_ren for the configured depth.
// Optional feature macro: TF_ROM_ERR_CHK_EN adds a ROM-word range check against
// modulus. A word that is out of range raises a sticky err and aborts the sequence.
`ifndef D_width
`define D_width 32
`endif

module tf_seq_ctrl #(
    parameter int unsigned ROM_AW = 10,
    parameter int unsigned WPS    = 29
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [`D_width-1:0]    cfg_last_l,
    input  logic [`D_width-1:0]    cfg_depth,
    output logic                   rom_ren,
    output logic [ROM_AW-1:0]      rom_addr,
    input  logic [`D_width-1:0]    rom_rdata,
    input  logic [`D_width-1:0]    modulus,
    output logic [15*`D_width-1:0] TF_base_bus,
    output logic [14*`D_width-1:0] TF_const_bus,
    output logic                   TF_wen,
    output logic                   TF_ren,
    output logic [`D_width-1:0]    it_depth_cnt,
    output logic [`D_width-1:0]    l,
    output logic                   LAST_STAGE,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned DW = `D_width;
    localparam int unsigned NB = 15;
    localparam int unsigned NC = 14;
    localparam int unsigned FW = $clog2(WPS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                  state_q, state_n;
    logic [FW-1:0]           fcnt_q, fcnt_n;
    logic [ROM_AW-1:0]       sbase_q, sbase_n;
    logic [DW-1:0]           last_l_q, last_l_n;
    logic [DW-1:0]           depth_q, depth_n;
    logic [DW-1:0]           l_q, l_n;
    logic [NB-1:0][DW-1:0]   base_q, base_n;
    logic [NC-1:0][DW-1:0]   const_q, const_n;
    logic                    ren_q, ren_n;
    logic [ROM_AW-1:0]       addr_q, addr_n;
    logic                    wen_q, wen_n;
    logic                    tfren_q, tfren_n;
    logic [DW-1:0]           itc_q, itc_n;
    logic                    last_q, last_n;
    logic                    busy_q, busy_n;
    logic                    done_q, done_n;
    logic                    err_q, err_n;
    logic [FW-1:0]           widx;
    logic [DW-1:0]           run_last;
    logic                    bad;

`ifndef TF_ROM_ERR_CHK_EN
    logic unused_modulus;
    assign unused_modulus = ^modulus;
`endif

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_n  = state_q;
        fcnt_n   = fcnt_q;
        sbase_n  = sbase_q;
        last_l_n = last_l_q;
        depth_n  = depth_q;
        l_n      = l_q;
        base_n   = base_q;
        const_n  = const_q;
        err_n    = err_q;
        ren_n    = 1'b0;
        addr_n   = '0;
        wen_n    = 1'b0;
        tfren_n  = 1'b0;
        itc_n    = '0;
        done_n   = 1'b0;
        bad      = 1'b0;
        widx     = fcnt_q - FW'(1);
        run_last = (depth_q == '0) ? '0 : depth_q - DW'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_FETCH;
                    last_l_n = cfg_last_l;
                    depth_n  = cfg_depth;
                    l_n      = '0;
                    sbase_n  = '0;
                    fcnt_n   = '0;
                    ren_n    = 1'b1;
                    addr_n   = '0;
                end
            end
            S_FETCH: begin
                // Word issued on the previous FETCH cycle is on rom_rdata now.
                if (fcnt_q != '0) begin
                    for (int i = 0; i < int'(NB); i++) begin
                        if (widx == FW'(i)) base_n[i] = rom_rdata;
                    end
                    for (int j = 0; j < int'(NC); j++) begin
                        if (widx == FW'(int'(NB) + j)) const_n[j] = rom_rdata;
                    end
`ifdef TF_ROM_ERR_CHK_EN
                    if (rom_rdata >= modulus) bad = 1'b1;
`endif
                end
                if (bad) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                end else if (fcnt_q == FW'(WPS)) begin
                    state_n = S_WRITE;
                    wen_n   = 1'b1;
                end else begin
                    fcnt_n = fcnt_q + FW'(1);
                    if (fcnt_n != FW'(WPS)) begin
                        ren_n  = 1'b1;
                        addr_n = sbase_q + ROM_AW'(fcnt_n);
                    end
                end
            end
            S_WRITE: begin
                state_n = S_RUN;
                tfren_n = 1'b1;
                itc_n   = '0;
            end
            S_RUN: begin
                if (itc_q == run_last) begin
                    state_n = (l_q == last_l_q) ? S_DONE : S_NEXT;
                end else begin
                    tfren_n = 1'b1;
                    itc_n   = itc_q + DW'(1);
                end
            end
            S_NEXT: begin
                state_n = S_FETCH;
                l_n     = l_q + DW'(1);
                sbase_n = sbase_q + ROM_AW'(WPS);
                fcnt_n  = '0;
                ren_n   = 1'b1;
                addr_n  = sbase_n;
            end
            S_DONE: begin
                state_n = S_IDLE;
                done_n  = 1'b1;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
        last_n = (l_n == last_l_n);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            fcnt_q   <= '0;
            sbase_q  <= '0;
            last_l_q <= '0;
            depth_q  <= '0;
            l_q      <= '0;
            base_q   <= '0;
            const_q  <= '0;
            ren_q    <= 1'b0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            tfren_q  <= 1'b0;
            itc_q    <= '0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            fcnt_q   <= fcnt_n;
            sbase_q  <= sbase_n;
            last_l_q <= last_l_n;
            depth_q  <= depth_n;
            l_q      <= l_n;
            base_q   <= base_n;
            const_q  <= const_n;
            ren_q    <= ren_n;
            addr_q   <= addr_n;
            wen_q    <= wen_n;
            tfren_q  <= tfren_n;
            itc_q    <= itc_n;
            last_q   <= last_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            err_q    <= err_n;
        end
    end

    assign rom_ren      = ren_q;
    assign rom_addr     = addr_q;
    assign TF_base_bus  = base_q;
    assign TF_const_bus = const_q;
    assign TF_wen       = wen_q;
    assign TF_ren       = tfren_q;
    assign it_depth_cnt = itc_q;
    assign l            = l_q;
    assign LAST_STAGE   = last_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_tf_seq_ctrl.sv
// tb_tf_seq_ctrl: directed, table-driven bench for tf_seq_ctrl with a behavioural ROM.
`timescale 1ns/1ps
`ifndef D_width
`define D_width 32
`endif

module tb_tf_seq_ctrl;

    localparam int unsigned DW  = `D_width;
    localparam int unsigned AW  = 10;
    localparam int unsigned WPS = 29;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [DW-1:0]       cfg_last_l;
    logic [DW-1:0]       cfg_depth;
    logic                rom_ren;
    logic [AW-1:0]       rom_addr;
    logic [DW-1:0]       rom_rdata;
    logic [DW-1:0]       modulus;
    logic [15*DW-1:0]    TF_base_bus;
    logic [14*DW-1:0]    TF_const_bus;
    logic                TF_wen;
    logic                TF_ren;
    logic [DW-1:0]       it_depth_cnt;
    logic [DW-1:0]       l;
    logic                LAST_STAGE;
    logic                busy;
    logic                done;
    logic                err;

    logic [DW-1:0]       rom_mem [0:1023];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int last_l;
        int depth;
        int repulse;   // cycle on which start is pulsed again (0 = never)
        int exp_done;  // cycle (start cycle = 0) on which done is seen
        int exp_wen;
        int exp_ren;
        int exp_rren;
    } vec_t;

    vec_t vecs [5];

    tf_seq_ctrl #(.ROM_AW(AW), .WPS(WPS)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_last_l   (cfg_last_l),
        .cfg_depth    (cfg_depth),
        .rom_ren      (rom_ren),
        .rom_addr     (rom_addr),
        .rom_rdata    (rom_rdata),
        .modulus      (modulus),
        .TF_base_bus  (TF_base_bus),
        .TF_const_bus (TF_const_bus),
        .TF_wen       (TF_wen),
        .TF_ren       (TF_ren),
        .it_depth_cnt (it_depth_cnt),
        .l            (l),
        .LAST_STAGE   (LAST_STAGE),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // One-cycle-latency ROM.
    always @(posedge clk) begin
        if (rom_ren) rom_rdata <= rom_mem[rom_addr];
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one table entry; called at a negedge, returns at a negedge.
    task automatic run_vec(input vec_t v, input int idx);
        int rren = 0, wen = 0, ren = 0, kk = 0, ridx = 0;
        int addr_bad = 0, l_bad = 0, bus_bad = 0, itc_bad = 0, ovl = 0, ls_bad = 0;
        int first_ren = 0, done_cyc = 0;
        logic [DW-1:0] w;
        cfg_last_l = DW'(v.last_l);
        cfg_depth  = DW'(v.depth);
        start      = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (rom_ren) begin
                rren++;
                if (rom_addr != AW'(wen * int'(WPS) + kk)) addr_bad++;
                if (l != DW'(wen)) l_bad++;
                kk++;
            end
            if (TF_wen) begin
                for (int i = 0; i < 15; i++) begin
                    w = TF_base_bus[i*DW +: DW];
                    if (w != DW'(wen * int'(WPS) + i + 1)) bus_bad++;
                end
                for (int j = 0; j < 14; j++) begin
                    w = TF_const_bus[j*DW +: DW];
                    if (w != DW'(wen * int'(WPS) + 15 + j + 1)) bus_bad++;
                end
                wen++;
                kk = 0;
            end
            if (TF_ren) begin
                if (first_ren == 0) first_ren = cyc;
                if (it_depth_cnt != DW'(ridx)) itc_bad++;
                ridx++;
                ren++;
            end else begin
                if (it_depth_cnt != '0) itc_bad++;
                ridx = 0;
            end
            if (TF_ren && TF_wen) ovl++;
            if (busy && (LAST_STAGE != (l == DW'(v.last_l)))) ls_bad++;
            start = (cyc + 1 == v.repulse);
            if (cyc == 1) begin
                cfg_last_l = DW'(7);
                cfg_depth  = DW'(9);
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
        chk($sformatf("v%0d done_cycle", idx), done_cyc, v.exp_done);
        chk($sformatf("v%0d first_ren_latency", idx), first_ren, 32);
        chk($sformatf("v%0d wen_count", idx), wen, v.exp_wen);
        chk($sformatf("v%0d ren_count", idx), ren, v.exp_ren);
        chk($sformatf("v%0d rom_ren_count", idx), rren, v.exp_rren);
        chk($sformatf("v%0d addr_errors", idx), addr_bad, 0);
        chk($sformatf("v%0d l_errors", idx), l_bad, 0);
        chk($sformatf("v%0d bus_errors", idx), bus_bad, 0);
        chk($sformatf("v%0d itc_errors", idx), itc_bad, 0);
        chk($sformatf("v%0d wen_ren_overlap", idx), ovl, 0);
        chk($sformatf("v%0d last_stage_errors", idx), ls_bad, 0);
        chk($sformatf("v%0d busy_at_done", idx), busy, 0);
        chk($sformatf("v%0d err", idx), err, 0);
        @(negedge clk);
        chk($sformatf("v%0d done_pulse_width", idx), done, 0);
        chk($sformatf("v%0d l_final", idx), l, v.last_l);
        @(negedge clk);
    endtask

    initial begin
        int found;
        vecs[0] = '{last_l: 0, depth: 4, repulse: 0,  exp_done: 37,  exp_wen: 1, exp_ren: 4, exp_rren: 29};
        vecs[1] = '{last_l: 2, depth: 2, repulse: 33, exp_done: 103, exp_wen: 3, exp_ren: 6, exp_rren: 87};
        vecs[2] = '{last_l: 0, depth: 0, repulse: 0,  exp_done: 34,  exp_wen: 1, exp_ren: 1, exp_rren: 29};
        vecs[3] = '{last_l: 1, depth: 1, repulse: 0,  exp_done: 67,  exp_wen: 2, exp_ren: 2, exp_rren: 58};
        vecs[4] = '{last_l: 1, depth: 3, repulse: 34, exp_done: 71,  exp_wen: 2, exp_ren: 6, exp_rren: 58};

        for (int a = 0; a < 1024; a++) rom_mem[a] = DW'(a + 1);
        rst        = 1'b0;
        start      = 1'b0;
        cfg_last_l = '0;
        cfg_depth  = '0;
        modulus    = DW'(1000);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst rom_ren", rom_ren, 0);
        chk("rst rom_addr", rom_addr, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst wen_ren", {TF_wen, TF_ren}, 0);
        chk("rst last_stage", LAST_STAGE, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) run_vec(vecs[v], v);

        // Reset while fetching word 10, then restart on the first cycle out of reset.
        cfg_last_l = DW'(1);
        cfg_depth  = DW'(2);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 50; c++) begin
            if (rom_ren && rom_addr == AW'(10)) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("midfetch reached_word10", found, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("midfetch rom_ren", rom_ren, 0);
        chk("midfetch rom_addr", rom_addr, 0);
        chk("midfetch busy", busy, 0);
        chk("midfetch base_bus_nonzero", |TF_base_bus, 0);
        chk("midfetch const_bus_nonzero", |TF_const_bus, 0);
        chk("midfetch l_itc", l | it_depth_cnt, 0);
        chk("midfetch flags", {TF_wen, TF_ren, LAST_STAGE, done, err}, 0);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart rom_ren", rom_ren, 1);
        chk("restart rom_addr", rom_addr, 0);
        chk("restart busy", busy, 1);

        // Reset while TF_ren is streaming.
        found = 0;
        for (int c = 0; c < 60; c++) begin
            if (TF_ren) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("midrun reached_run", found, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrun TF_ren", TF_ren, 0);
        chk("midrun busy", busy, 0);
        chk("midrun it_depth_cnt", it_depth_cnt, 0);
        rst = 1'b1;
        @(negedge clk);

`ifdef TF_ROM_ERR_CHK_EN
        // Out-of-range ROM word aborts the sequence and latches err.
        begin
            int wcnt = 0, dcnt = 0;
            rom_mem[5] = DW'(97);
            modulus    = DW'(97);
            cfg_last_l = '0;
            cfg_depth  = DW'(4);
            start      = 1'b1;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                start = 1'b0;
                if (TF_wen) wcnt++;
                if (done) dcnt++;
            end
            chk("errchk err", err, 1);
            chk("errchk wen_count", wcnt, 0);
            chk("errchk done_count", dcnt, 0);
            chk("errchk busy", busy, 0);
            repeat (5) @(negedge clk);
            chk("errchk err_sticky", err, 1);
            rst = 1'b0;
            @(negedge clk);
            chk("errchk err_cleared", err, 0);
            rst        = 1'b1;
            rom_mem[5] = DW'(6);
            modulus    = DW'(1000);
            @(negedge clk);
        end
`else
        chk("noerrchk err", err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
